// File: rtl/pipelined_hit_detector_if.sv
// Request/response bundle for pipelined_hit_detector: one set's tags, valid bits and
// lines in, hit / way / line out, each direction with its own valid/ready handshake.
interface pipelined_hit_detector_if #(
    parameter int WAYS      = 8,
    parameter int TAG_BITS  = 10,
    parameter int LINE_BITS = 512
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                      req_valid;
    logic                      req_ready;
    logic [TAG_BITS-1:0]       req_tag;
    logic [WAYS-1:0]           req_way_valid;
    logic [TAG_BITS*WAYS-1:0]  req_cache_tags;
    logic [LINE_BITS*WAYS-1:0] req_cache_data;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic                      rsp_hit;
    logic [WAY_BITS-1:0]       rsp_way;
    logic [LINE_BITS-1:0]      rsp_line;
    logic                      rsp_multi_hit;

    modport master (
        output req_valid, req_tag, req_way_valid, req_cache_tags, req_cache_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_line, rsp_multi_hit
    );

    modport slave (
        input  req_valid, req_tag, req_way_valid, req_cache_tags, req_cache_data, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_line, rsp_multi_hit
    );
endinterface

// File: rtl/pipelined_hit_detector.sv
// Two-stage tag-match pipeline for the set-associative L2 model with saturating hit/miss
// statistics. Define HIT_DETECT_MULTIHIT_EN to build the multi-hit flag (popcount > 1).
module pipelined_hit_detector #(
    parameter int WAYS      = 8,
    parameter int TAG_BITS  = 10,
    parameter int LINE_BITS = 512,
    parameter int CNT_BITS  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipelined_hit_detector_if.slave bus,
    input  logic                  cnt_clear,
    output logic [CNT_BITS-1:0]   hit_count,
    output logic [CNT_BITS-1:0]   miss_count
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic [WAYS-1:0]           match_p0;
    logic [WAYS-1:0]           match_p1;
    logic [WAYS*LINE_BITS-1:0] lines_p1;
    logic                      vld_p1;
    logic                      hit_p1;
    logic [WAY_BITS-1:0]       way_p1;
    logic [LINE_BITS-1:0]      line_p1;
    logic                      vld_p2;
    logic                      hit_p2;
    logic [WAY_BITS-1:0]       way_p2;
    logic [LINE_BITS-1:0]      line_p2;
    logic                      s2_load;
    logic                      accept_req;
    logic                      accept_rsp;

    function automatic logic [WAY_BITS-1:0] lowest_way(input logic [WAYS-1:0] m);
        lowest_way = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (m[i]) lowest_way = WAY_BITS'(i);
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        sat_inc = (&v) ? v : v + 1'b1;
    endfunction

`ifdef HIT_DETECT_MULTIHIT_EN
    logic multi_p2;

    function automatic logic multi_match(input logic [WAYS-1:0] m);
        multi_match = ($countones(m) > 1);
    endfunction
`endif

    // Stage 0: tag compare on the incoming set, invalid ways masked off
    always_comb begin
        match_p0 = '0;
        for (int i = 0; i < WAYS; i++)
            match_p0[i] = bus.req_way_valid[i] &&
                          (bus.req_cache_tags[i*TAG_BITS +: TAG_BITS] == bus.req_tag);
    end

    // S2 takes new data when empty or drained; S1 can refill whenever S2 loads
    assign s2_load       = !vld_p2 || bus.rsp_ready;
    assign bus.req_ready = !vld_p1 || s2_load;
    assign accept_req    = bus.req_valid && bus.req_ready;
    assign accept_rsp    = vld_p2 && bus.rsp_ready;

    // Stage 1: match vector and all lines of the set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                vld_p1 <= 1'b0;
        else if (bus.req_ready) vld_p1 <= bus.req_valid;
    end

    always_ff @(posedge clk) begin
        if (accept_req) begin
            match_p1 <= match_p0;
            lines_p1 <= bus.req_cache_data;
        end
    end

    always_comb begin
        hit_p1  = |match_p1;
        way_p1  = lowest_way(match_p1);
        line_p1 = hit_p1 ? lines_p1[way_p1*LINE_BITS +: LINE_BITS] : '0;
    end

    // Stage 2: registered response, held while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            hit_p2   <= 1'b0;
            way_p2   <= '0;
            line_p2  <= '0;
`ifdef HIT_DETECT_MULTIHIT_EN
            multi_p2 <= 1'b0;
`endif
        end else if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                hit_p2   <= hit_p1;
                way_p2   <= way_p1;
                line_p2  <= line_p1;
`ifdef HIT_DETECT_MULTIHIT_EN
                multi_p2 <= multi_match(match_p1);
`endif
            end
        end
    end

    assign bus.rsp_valid = vld_p2;
    assign bus.rsp_hit   = hit_p2;
    assign bus.rsp_way   = way_p2;
    assign bus.rsp_line  = line_p2;

`ifdef HIT_DETECT_MULTIHIT_EN
    assign bus.rsp_multi_hit = multi_p2;
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && accept_rsp && multi_p2)
            $display("pipelined_hit_detector: warning, multi-way hit, reporting way %0d", way_p2);
    end
`endif
`else
    assign bus.rsp_multi_hit = 1'b0;
`endif

    // Statistics count delivered responses only; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (cnt_clear) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept_rsp) begin
            if (hit_p2) hit_count  <= sat_inc(hit_count);
            else        miss_count <= sat_inc(miss_count);
        end
    end
endmodule

// File: tb/tb_pipelined_hit_detector.sv
// Directed, table-driven bench for pipelined_hit_detector (8 ways, 32-bit lines,
// 4-bit counters so saturation is reachable) plus backpressure, clear and reset sequences.
module tb_pipelined_hit_detector;
    localparam int WAYS      = 8;
    localparam int TAG_BITS  = 10;
    localparam int LINE_BITS = 32;
    localparam int CNT_BITS  = 4;
    localparam int NVEC      = 7;

    typedef struct {
        logic [TAG_BITS-1:0]      tag;
        logic [WAYS-1:0]          wv;
        logic [TAG_BITS*WAYS-1:0] tags;
        logic                     hit;
        logic [2:0]               way;
        logic [LINE_BITS-1:0]     line;
        logic                     multi;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cnt_clear = 1'b0;
    logic [CNT_BITS-1:0] hit_count;
    logic [CNT_BITS-1:0] miss_count;

    pipelined_hit_detector_if #(.WAYS(WAYS), .TAG_BITS(TAG_BITS), .LINE_BITS(LINE_BITS)) bus ();

    pipelined_hit_detector #(
        .WAYS(WAYS), .TAG_BITS(TAG_BITS), .LINE_BITS(LINE_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cnt_clear(cnt_clear), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    vec_t vecs [NVEC];
    logic [LINE_BITS*WAYS-1:0] data_all;
    int n_checks = 0;
    int n_pass   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [TAG_BITS*WAYS-1:0] tags_with(input logic [TAG_BITS-1:0] t,
                                                           input logic [WAYS-1:0] sel);
        logic [TAG_BITS*WAYS-1:0] r;
        for (int i = 0; i < WAYS; i++)
            r[i*TAG_BITS +: TAG_BITS] = sel[i] ? t : TAG_BITS'(10'h300 + i);
        return r;
    endfunction

    function automatic logic exp_multi(input int v);
`ifdef HIT_DETECT_MULTIHIT_EN
        return vecs[v].multi;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int sat(input int v);
        return (v >= 15) ? 15 : v + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input int v);
        bus.req_tag        = vecs[v].tag;
        bus.req_way_valid  = vecs[v].wv;
        bus.req_cache_tags = vecs[v].tags;
        bus.req_cache_data = data_all;
    endtask

    task automatic count_rsp(input int v);
        if (vecs[v].hit) exp_hits = sat(exp_hits);
        else             exp_miss = sat(exp_miss);
    endtask

    task automatic run_single(input int v);
        bus.rsp_ready = 1'b1;
        drive_vec(v);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        check($sformatf("v%0d_latency_early", v), 64'(bus.rsp_valid), 64'd0);
        step();
        check($sformatf("v%0d_rsp_valid", v), 64'(bus.rsp_valid), 64'd1);
        check($sformatf("v%0d_hit", v), 64'(bus.rsp_hit), 64'(vecs[v].hit));
        check($sformatf("v%0d_way", v), 64'(bus.rsp_way), 64'(vecs[v].way));
        check($sformatf("v%0d_line", v), 64'(bus.rsp_line), 64'(vecs[v].line));
        check($sformatf("v%0d_multi", v), 64'(bus.rsp_multi_hit), 64'(exp_multi(v)));
        count_rsp(v);
        step();
        check($sformatf("v%0d_rsp_drop", v), 64'(bus.rsp_valid), 64'd0);
        check($sformatf("v%0d_hit_count", v), 64'(hit_count), 64'(exp_hits));
        check($sformatf("v%0d_miss_count", v), 64'(miss_count), 64'(exp_miss));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_q[$];
        int send_q[$];
        int stall;
        int idx;
        bit stalled_once;
        bit saw_not_ready;
        bit held_valid;
        logic [LINE_BITS+3:0] snap;

        for (int i = 0; i < WAYS; i++)
            data_all[i*LINE_BITS +: LINE_BITS] = {16'hA5A5, 8'(i), 8'(i)};

        vecs[0] = '{10'h02A, 8'hFF, tags_with(10'h02A, 8'b0010_0000), 1'b1, 3'd5, 32'hA5A5_0505, 1'b0};
        vecs[1] = '{10'h02A, 8'hF7, tags_with(10'h02A, 8'b0000_1000), 1'b0, 3'd0, 32'h0000_0000, 1'b0};
        vecs[2] = '{10'h300, 8'h00, tags_with(10'h300, 8'b0000_0000), 1'b0, 3'd0, 32'h0000_0000, 1'b0};
        vecs[3] = '{10'h155, 8'hFF, tags_with(10'h155, 8'b0100_0100), 1'b1, 3'd2, 32'hA5A5_0202, 1'b1};
        vecs[4] = '{10'h300, 8'hFF, tags_with(10'h300, 8'b0000_0000), 1'b1, 3'd0, 32'hA5A5_0000, 1'b0};
        vecs[5] = '{10'h077, 8'hFF, tags_with(10'h077, 8'b1000_0000), 1'b1, 3'd7, 32'hA5A5_0707, 1'b0};
        vecs[6] = '{10'h3FF, 8'hFF, tags_with(10'h3FF, 8'b0000_0000), 1'b0, 3'd0, 32'h0000_0000, 1'b0};

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_vec(0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset_hit_count", 64'(hit_count), 64'd0);
        check("reset_miss_count", 64'(miss_count), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_req_ready", 64'(bus.req_ready), 64'd1);
        step();

        for (int v = 0; v < NVEC; v++) run_single(v);

        // Back-to-back requests with a three-cycle consumer stall
        exp_q = '{0, 4, 5, 6};
        send_q = '{0, 4, 5, 6};
        stall = 0;
        stalled_once = 1'b0;
        saw_not_ready = 1'b0;
        held_valid = 1'b0;
        snap = '0;
        for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
            if (send_q.size() > 0) begin
                drive_vec(send_q[0]);
                bus.req_valid = 1'b1;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (bus.rsp_valid && !stalled_once) begin
                stall = 3;
                stalled_once = 1'b1;
            end
            bus.rsp_ready = (stall == 0);
            if (stall > 0) stall--;
            #1;
            if (held_valid)
                check("bp_held_stable", 64'({bus.rsp_valid, bus.rsp_hit, bus.rsp_way, bus.rsp_line}),
                      64'({1'b1, snap}));
            held_valid = bus.rsp_valid && !bus.rsp_ready;
            snap = {bus.rsp_hit, bus.rsp_way, bus.rsp_line};
            if (bus.req_valid && !bus.req_ready) saw_not_ready = 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) begin
                idx = exp_q.pop_front();
                check("bp_order_hit", 64'(bus.rsp_hit), 64'(vecs[idx].hit));
                check("bp_order_way", 64'(bus.rsp_way), 64'(vecs[idx].way));
                check("bp_order_line", 64'(bus.rsp_line), 64'(vecs[idx].line));
                count_rsp(idx);
            end
            if (bus.req_valid && bus.req_ready) void'(send_q.pop_front());
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        check("bp_all_received", 64'(exp_q.size()), 64'd0);
        check("bp_req_ready_low", 64'(saw_not_ready), 64'd1);
        check("bp_no_duplicate", 64'(bus.rsp_valid), 64'd0);
        check("bp_hit_count", 64'(hit_count), 64'(exp_hits));
        check("bp_miss_count", 64'(miss_count), 64'(exp_miss));

        // Saturation: 16 more hits streamed at full rate
        drive_vec(0);
        bus.req_valid = 1'b1;
        repeat (16) step();
        bus.req_valid = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 16; i++) exp_hits = sat(exp_hits);
        check("sat_hit_count", 64'(hit_count), 64'(exp_hits));
        check("sat_miss_count", 64'(miss_count), 64'(exp_miss));

        // Clear coinciding with an accepted hit
        drive_vec(0);
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        check("clr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        check("clr_hit_count", 64'(hit_count), 64'd0);
        check("clr_miss_count", 64'(miss_count), 64'd0);
        run_single(5);

        // Asynchronous reset with both stages full
        bus.rsp_ready = 1'b0;
        drive_vec(4);
        bus.req_valid = 1'b1;
        step();
        drive_vec(5);
        step();
        bus.req_valid = 1'b0;
        check("flush_pre_valid", 64'(bus.rsp_valid), 64'd1);
        check("flush_pre_ready", 64'(bus.req_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check("flush_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("flush_hit_count", 64'(hit_count), 64'd0);
        check("flush_miss_count", 64'(miss_count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("flush_req_ready", 64'(bus.req_ready), 64'd1);
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_response", 64'(bus.rsp_valid), 64'd0);
        end
        check("flush_counts_stay", 64'({hit_count, miss_count}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
